// File: rtl/axis_iter_div.sv
// Iterative 32-bit restoring divider with AXI-Stream style operand channels.
// One quotient bit per cycle; 64-bit result {quotient, remainder} pulses once when done.
module axis_iter_div #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        s_axis_dividend_tvalid,
  output logic        s_axis_dividend_tready,
  input  logic [31:0] s_axis_dividend_tdata,
  input  logic        s_axis_divisor_tvalid,
  output logic        s_axis_divisor_tready,
  input  logic [31:0] s_axis_divisor_tdata,
  output logic        m_axis_dout_tvalid,
  output logic [63:0] m_axis_dout_tdata
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  count;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;

  logic        accept;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic [31:0] quo_step;
  logic [31:0] rem_step;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign accept = (state == IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid && !flush;

  assign dvd_mag = (SIGNED && s_axis_dividend_tdata[31]) ? (~s_axis_dividend_tdata + 32'd1)
                                                          : s_axis_dividend_tdata;
  assign dvs_mag = (SIGNED && s_axis_divisor_tdata[31]) ? (~s_axis_divisor_tdata + 32'd1)
                                                         : s_axis_divisor_tdata;

  // The partial remainder stays below the divisor, so bit 32 of diff is a clean borrow flag;
  // a zero divisor never borrows and yields an all-ones quotient with remainder = dividend.
  always_comb begin
    rem_shift = {rem, quo[31]};
    diff      = rem_shift - {1'b0, dvs};
    quo_step  = {quo[30:0], ~diff[32]};
    rem_step  = diff[32] ? rem_shift[31:0] : diff[31:0];
    quo_fix   = neg_q ? (~quo_step + 32'd1) : quo_step;
    rem_fix   = neg_r ? (~rem_step + 32'd1) : rem_step;
  end

  // NOTE: every output of a combinational process gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = CALC;
        CALC:    if (count == 5'd31) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      count             <= 5'd0;
      quo               <= 32'd0;
      rem               <= 32'd0;
      dvs               <= 32'd0;
      neg_q             <= 1'b0;
      neg_r             <= 1'b0;
      m_axis_dout_tdata <= 64'd0;
    end else begin
      state <= state_next;
      if (!flush) begin
        case (state)
          IDLE: if (accept) begin
            quo   <= dvd_mag;
            dvs   <= dvs_mag;
            rem   <= 32'd0;
            count <= 5'd0;
            neg_q <= SIGNED && (s_axis_dividend_tdata[31] ^ s_axis_divisor_tdata[31]);
            neg_r <= SIGNED && s_axis_dividend_tdata[31];
          end
          CALC: begin
            quo   <= quo_step;
            rem   <= rem_step;
            count <= count + 5'd1;
            if (count == 5'd31) m_axis_dout_tdata <= {quo_fix, rem_fix};
          end
          default: ;
        endcase
      end
    end
  end

  assign s_axis_dividend_tready = (state == IDLE);
  assign s_axis_divisor_tready  = (state == IDLE);
  assign m_axis_dout_tvalid     = (state == DONE);

endmodule

// File: tb/tb_axis_iter_div.sv
// Scoreboard bench for axis_iter_div: signed and unsigned instances share stimulus;
// the issuer pushes expected {data, cycle} entries, a negedge monitor pops and compares.
module tb_axis_iter_div;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] es;
    logic [63:0] eu;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        dd_valid = 1'b0;
  logic [31:0] dd_data = 32'd0;
  logic        dv_valid = 1'b0;
  logic [31:0] dv_data = 32'd0;

  logic        dd_ready_s, dv_ready_s, tvalid_s;
  logic        dd_ready_u, dv_ready_u, tvalid_u;
  logic [63:0] tdata_s, tdata_u;
  logic        rdy_all;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;
  exp_t q_s[$];
  exp_t q_u[$];

  assign rdy_all = dd_ready_s & dv_ready_s & dd_ready_u & dv_ready_u;

  axis_iter_div #(.SIGNED(1'b1)) u_s (
    .clk(clk), .rst(rst), .flush(flush),
    .s_axis_dividend_tvalid(dd_valid), .s_axis_dividend_tready(dd_ready_s),
    .s_axis_dividend_tdata(dd_data),
    .s_axis_divisor_tvalid(dv_valid), .s_axis_divisor_tready(dv_ready_s),
    .s_axis_divisor_tdata(dv_data),
    .m_axis_dout_tvalid(tvalid_s), .m_axis_dout_tdata(tdata_s)
  );

  axis_iter_div #(.SIGNED(1'b0)) u_u (
    .clk(clk), .rst(rst), .flush(flush),
    .s_axis_dividend_tvalid(dd_valid), .s_axis_dividend_tready(dd_ready_u),
    .s_axis_dividend_tdata(dd_data),
    .s_axis_divisor_tvalid(dv_valid), .s_axis_divisor_tready(dv_ready_u),
    .s_axis_divisor_tdata(dv_data),
    .m_axis_dout_tvalid(tvalid_u), .m_axis_dout_tdata(tdata_u)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected entry, in data and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (tvalid_s || tvalid_u) pulses++;
    if (tvalid_s) begin
      if (q_s.size() == 0) check("unexpected_pulse_s", 64'd1, 64'd0);
      else begin
        e = q_s.pop_front();
        check("result_s", tdata_s, e.data);
        check("latency_s", 64'(cyc), 64'(e.cyc));
      end
    end
    if (tvalid_u) begin
      if (q_u.size() == 0) check("unexpected_pulse_u", 64'd1, 64'd0);
      else begin
        e = q_u.pop_front();
        check("result_u", tdata_u, e.data);
        check("latency_u", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic push_exp(input logic [63:0] es, input logic [63:0] eu, input int n);
    q_s.push_back('{data: es, cyc: n + 33});
    q_u.push_back('{data: eu, cyc: n + 33});
  endtask

  // Offers one operand pair; returns the acceptance cycle (-1 on timeout).
  task automatic issue(input vec_t v, input bit expect_out, output int acc);
    int n = 0;
    acc = -1;
    @(posedge clk); #1;
    dd_valid = 1'b1; dd_data = v.a;
    dv_valid = 1'b1; dv_data = v.b;
    forever begin
      @(negedge clk);
      if (rdy_all) break;
      n++;
      if (n > 100) break;
    end
    if (n > 100) check("issue_timeout", 64'd1, 64'd0);
    else begin
      acc = cyc;
      if (expect_out) push_exp(v.es, v.eu, acc);
    end
    @(posedge clk); #1;
    dd_valid = 1'b0; dd_data = 32'hDEAD_BEEF;
    dv_valid = 1'b0; dv_data = 32'hCAFE_F00D;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q_s.size() != 0 || q_u.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(q_s.size() + q_u.size()), 64'd0);
    @(negedge clk);
  endtask

  vec_t vecs[7] = '{
    '{32'd100,        32'd7,          {32'h0000000E, 32'h00000002}, {32'h0000000E, 32'h00000002}},
    '{32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFD, 32'hFFFFFFFF}, {32'h7FFFFFFC, 32'h00000001}},
    '{32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'h00000000}, {32'h00000000, 32'h80000000}},
    '{32'hFFFFFFFB,   32'd0,          {32'h00000001, 32'hFFFFFFFB}, {32'hFFFFFFFF, 32'hFFFFFFFB}},
    '{32'h12345678,   32'd0,          {32'hFFFFFFFF, 32'h12345678}, {32'hFFFFFFFF, 32'h12345678}},
    '{32'hFFFFFF9C,   32'd7,          {32'hFFFFFFF2, 32'hFFFFFFFE}, {32'h24924916, 32'h00000002}},
    '{32'd7,          32'hFFFFFFFE,   {32'hFFFFFFFD, 32'h00000001}, {32'h00000000, 32'h00000007}}
  };

  initial begin
    int acc, acc_prev, n, base;
    vec_t v93;
    v93 = '{32'd9, 32'd3, {32'h00000003, 32'h00000000}, {32'h00000003, 32'h00000000}};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", {62'd0, tvalid_s, tvalid_u}, 64'd0);
    check("rst_tdata_s", tdata_s, 64'd0);
    check("rst_tdata_u", tdata_u, 64'd0);
    check("rst_ready", {63'd0, rdy_all}, 64'd1);
    @(posedge clk); #1 rst = 1'b0;

    // Directed vectors back to back
    acc_prev = -1;
    foreach (vecs[i]) begin
      issue(vecs[i], 1'b1, acc);
      if (i == 1) check("b2b_gap", 64'(acc - acc_prev), 64'd34);
      acc_prev = acc;
    end
    wait_idle();
    check("hold_tdata_s", tdata_s, vecs[6].es);
    check("hold_tdata_u", tdata_u, vecs[6].eu);

    // Dividend alone for 5 cycles, then divisor; hold both for a second op
    @(posedge clk); #1;
    dd_valid = 1'b1; dd_data = 32'd100; dv_data = 32'd55;
    repeat (5) begin
      @(negedge clk);
      check("ready_dividend_alone", {63'd0, rdy_all}, 64'd1);
    end
    @(posedge clk); #1;
    dv_valid = 1'b1; dv_data = 32'd7;
    @(negedge clk);
    check("ready_both_valid", {63'd0, rdy_all}, 64'd1);
    base = cyc;
    push_exp(vecs[0].es, vecs[0].eu, base);
    @(negedge clk);
    check("ready_low_calc", {63'd0, rdy_all}, 64'd0);
    n = 0;
    while (!rdy_all && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("second_accept_cycle", 64'(cyc), 64'(base + 34));
    push_exp(vecs[0].es, vecs[0].eu, cyc);
    @(posedge clk); #1;
    dd_valid = 1'b0; dv_valid = 1'b0;
    wait_idle();

    // Flush at CALC cycle 10
    issue(v93, 1'b0, acc);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("ready_after_flush", {63'd0, rdy_all}, 64'd1);
    n = pulses;
    repeat (40) @(negedge clk);
    check("no_pulse_after_flush", 64'(pulses - n), 64'd0);
    issue(v93, 1'b1, acc);
    wait_idle();

    // Reset at CALC cycle 20
    issue(vecs[1], 1'b0, acc);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_tvalid", {62'd0, tvalid_s, tvalid_u}, 64'd0);
    check("midrst_tdata_s", tdata_s, 64'd0);
    check("midrst_tdata_u", tdata_u, 64'd0);
    check("midrst_ready", {63'd0, rdy_all}, 64'd1);
    n = pulses;
    repeat (40) @(negedge clk);
    check("no_pulse_after_rst", 64'(pulses - n), 64'd0);
    issue(vecs[5], 1'b1, acc);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
